// File: rtl/conv_pkg.sv
// conv_pkg: shared encoder/decoder constants, default polynomials and FSM states
package conv_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        TAIL   = 2'd2,
        DRAIN  = 2'd3
    } state_t;
    localparam int         K_DEF  = 3;
    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;
endpackage

// File: rtl/conv_sym_gen.sv
// conv_sym_gen: combinational code symbol {c1,c0} from current bit b and past bits sr
// Ports: b (current bit), sr (K-1 past bits, sr[K-2] newest), sym ({c1,c0})
module conv_sym_gen
    import conv_pkg::*;
#(
    parameter int           K  = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic         b,
    input  logic [K-2:0] sr,
    output logic [1:0]   sym
);
    logic [K-1:0] w;
    assign w   = {b, sr};
    assign sym = {^(w & G1), ^(w & G0)};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 streaming convolutional encoder with zero-tail termination
// Ports: clk/rst (sync, active-high); start begins a frame from IDLE;
//        in_valid/in_bit/in_ready information bit handshake;
//        out_valid/out_sym/out_ready code symbol handshake ({c1,c0});
//        busy (not IDLE), done (final symbol consumed), error (start while busy)
module conv_encoder
    import conv_pkg::*;
#(
    parameter int           K         = K_DEF,
    parameter logic [K-1:0] G0        = G0_DEF,
    parameter logic [K-1:0] G1        = G1_DEF,
    parameter int           FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_sym,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam logic [7:0] LAST  = 8'(FRAME_LEN - 1);
    localparam logic [7:0] TLAST = 8'(K - 2);

    state_t       state, state_nxt;
    logic [K-2:0] sr;
    logic [7:0]   cnt;
    logic         free, load, b;
    logic [1:0]   sym;

    assign free     = !out_valid || out_ready;
    assign in_ready = (state == ENCODE) && free;
    assign busy     = state != IDLE;
    assign b        = (state == ENCODE) && in_bit;

    conv_sym_gen #(.K(K), .G0(G0), .G1(G1)) u_sym (
        .b  (b),
        .sr (sr),
        .sym(sym)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE:   state_nxt = start ? ENCODE : IDLE;
            ENCODE: begin
                load      = in_valid && free;
                state_nxt = (load && cnt == LAST) ? TAIL : ENCODE;
            end
            TAIL:   begin
                load      = free;
                state_nxt = (free && cnt == TLAST) ? DRAIN : TAIL;
            end
            DRAIN:  state_nxt = (out_valid && out_ready) ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= (state == DRAIN) && out_valid && out_ready;
            error <= start && busy;
            if (state == IDLE && start) begin
                sr  <= '0;
                cnt <= '0;
            end else if (load) begin
                sr  <= {b, sr[K-2:1]};
                // counter restarts on each phase change (ENCODE->TAIL, TAIL->DRAIN)
                cnt <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_sym   <= sym;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: randomized self-checking bench against a convolution-sum reference model
module tb_conv_encoder;
    localparam int         K    = 3;
    localparam int         FL   = 4;
    localparam int         NSYM = FL + K - 1;
    localparam logic [2:0] G0   = 3'b111;
    localparam logic [2:0] G1   = 3'b101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       error;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    conv_encoder #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_sym  (out_sym),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // symbol i = sum over taps j of G[K-1-j] * x[i-j] (mod 2), x = frame bits then K-1 zeros
    function automatic logic [1:0] model_sym(input logic [FL-1:0] bits, input int i);
        logic [K-1:0] g0 = G0;
        logic [K-1:0] g1 = G1;
        logic c0 = 1'b0;
        logic c1 = 1'b0;
        for (int j = 0; j < K; j++) begin
            int  t = i - j;
            logic x = (t >= 0 && t < FL) ? bits[t] : 1'b0;
            c0 ^= g0[K-1-j] & x;
            c1 ^= g1[K-1-j] & x;
        end
        return {c1, c0};
    endfunction

    // mode: 0 = all ready/valid, 1 = out_ready toggles 1,0,..., 2 = random
    task automatic run_frame(input logic [FL-1:0] bits, input int mode, input int err_at,
                             input int abort_at, input logic fixed);
        logic [1:0] tp[NSYM] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
        int         ni = 0, no = 0, cyc = 0;
        logic       stall = 1'b0, perr = 1'b0;
        logic [1:0] psym = 2'b00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (no < NSYM && cyc < 200 && no != abort_at) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            in_valid  = (ni < FL) ? ((mode == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
            in_bit    = (ni < FL) ? bits[ni] : 1'($urandom_range(0, 1));
            start     = (cyc == err_at);
            #1;
            check("busy", 8'(busy), 8'd1);
            check("error", 8'(error), 8'(perr));
            if (ni >= FL) check("in_ready_tail", 8'(in_ready), 8'd0);
            if (stall) begin
                check("hold_valid", 8'(out_valid), 8'd1);
                check("hold_sym", 8'(out_sym), 8'(psym));
            end
            stall = out_valid && !out_ready;
            psym  = out_sym;
            perr  = start;
            if (in_valid && in_ready) ni++;
            if (out_valid && out_ready) begin
                check("sym", 8'(out_sym), 8'(model_sym(bits, no)));
                if (fixed) check("sym_table", 8'(out_sym), 8'(tp[no]));
                no++;
            end
            cyc++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (no == abort_at) begin
            // reset mid-frame together with start: reset must win and drop the buffered symbol
            rst   = 1'b1;
            start = 1'b1;
            @(posedge clk); #1;
            rst   = 1'b0;
            start = 1'b0;
            check("rst_valid", 8'(out_valid), 8'd0);
            check("rst_busy", 8'(busy), 8'd0);
            check("rst_in_ready", 8'(in_ready), 8'd0);
            check("rst_done", 8'(done), 8'd0);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b0;
        check("nsym", 8'(no), 8'(NSYM));
        check("done", 8'(done), 8'd1);
        check("busy_end", 8'(busy), 8'd0);
        check("error_end", 8'(error), 8'(perr));
        if (mode == 0) check("cycles", 8'(cyc), 8'(NSYM + 1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_out_sym", 8'(out_sym), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_error", 8'(error), 8'd0);
        check("rst_in_ready", 8'(in_ready), 8'd0);
        rst = 1'b0;
        // in_valid held in IDLE must be ignored
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("idle_in_ready", 8'(in_ready), 8'd0);
            check("idle_out_valid", 8'(out_valid), 8'd0);
            check("idle_busy", 8'(busy), 8'd0);
        end
        in_valid = 1'b0;
        run_frame(4'b1101, 0, -1, -1, 1'b1);
        @(posedge clk); #1;
        check("done_pulse", 8'(done), 8'd0);
        run_frame(4'b1101, 1, -1, -1, 1'b1);
        run_frame(4'b1101, 2, 2, -1, 1'b1);
        run_frame(4'b0110, 0, -1, 2, 1'b0);
        run_frame(4'b0000, 2, -1, -1, 1'b0);
        // back-to-back: called in the done cycle, first bit 1 must give 11
        run_frame(4'b0000, 0, -1, -1, 1'b0);
        run_frame(4'b1011, 0, -1, -1, 1'b0);
        for (int f = 0; f < 30; f++) begin
            int err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_frame(4'($urandom), 2, err_at, -1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2 streaming convolutional encoder that produces the coded symbol stream consumed by the Viterbi decoder. It accepts a frame of FRAME_LEN information bits over a valid/ready handshake. For each bit it emits one 2-bit code symbol. After the last information bit it appends K-1 zero tail bits so the trellis terminates in state 0. The block sits at the transmit end of the channel model, directly upstream of the decoder's symbol input.

## Interface
- K, 3: constraint length; shift register holds K-1 bits; legal range 3..7.
- G0, 3'b111: generator polynomial for c0, K bits; bit K-1 taps the current input bit.
- G1, 3'b101: generator polynomial for c1, same tap convention.
- FRAME_LEN, 8: information bits per frame; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  in_bit is valid.
- in_bit  in  1  information bit.
- in_ready  out  1  encoder accepts in_bit this cycle.
- out_valid  out  1  out_sym holds an unconsumed symbol.
- out_sym  out  2  code symbol {c1,c0}.
- out_ready  in  1  downstream consumes out_sym this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final tail symbol is consumed.
- error  out  1  one-cycle pulse when start is asserted while busy.

## Operation
- State is a 2-bit register with the following states: IDLE=0, ENCODE=1, TAIL=2, DRAIN=3.
- Datapath:
  - sr[K-2:0] holds past bits; sr[K-2] is the newest.
  - Window w = {b, sr}.
  - c0 = ^(w & G0), c1 = ^(w & G1).
  - Shift update: sr <= {b, sr[K-2:1]}.
- Output buffer is a single register pair (out_valid, out_sym).
  - Buffer is free when !out_valid || out_ready.
  - Load and consume may occur in the same cycle; the buffer then stays full with the new symbol.
- IDLE:
  - On start: sr<=0, bit counter cnt<=0, go to ENCODE.
  - start while busy is ignored and pulses error.
- ENCODE:
  - in_ready = buffer free.
  - On in_valid && in_ready: encode b=in_bit, load buffer, shift sr, cnt++.
  - When cnt reaches FRAME_LEN-1 and that bit is accepted: cnt<=0, go to TAIL.
- TAIL:
  - in_ready=0.
  - Each cycle the buffer is free: encode b=0, load, shift, cnt++.
  - After the K-1st tail bit is loaded, go to DRAIN.
- DRAIN:
  - in_ready=0.
  - When out_valid && out_ready (the last symbol is consumed): pulse done, go to IDLE.
- Counter width: 8 bits; comparisons are exact; no wrap-around is reachable.
- in_valid outside ENCODE is ignored; no data is lost because in_ready is 0.
- Frame output length is always FRAME_LEN+K-1 symbols, and sr is all-zero after the tail.

## Timing
- Reset values:
  - state=IDLE, sr=0, cnt=0.
  - out_valid=0, out_sym=2'b00.
  - in_ready=0, busy=0, done=0, error=0.
- Reset mid-frame: at the next edge, drop the frame entirely, including any buffered symbol.
- Latency: out_sym for a bit accepted at edge N is valid in the cycle after edge N.
- Throughput: one symbol per cycle with out_ready held high.
- The first tail symbol is loaded on the edge after the last data bit is accepted, if the buffer is free.
- With out_ready held low:
  - out_sym and out_valid are held stable.
  - in_ready=0, and TAIL/DRAIN stall.
- done is asserted in the cycle after the final handshake edge, together with busy=0.
- A new start is accepted in the same cycle as done, since state is IDLE.
- Simultaneous start and rst: rst wins.
- in_ready is combinational from state and buffer occupancy.
- out_sym, out_valid, done and error are registered.

## Structure
- Shared package conv_pkg holds:
  - the state enum/localparams IDLE/ENCODE/TAIL/DRAIN,
  - default polynomials G0_DEF=3'b111, G1_DEF=3'b101,
  - K_DEF=3.
- The decoder's branch-metric logic imports the same polynomials from this package.
- One natural sub-module, conv_sym_gen: a combinational function of (b, sr) -> {c1,c0}, parameterised by K/G0/G1. It is shared with the decoder for expected-symbol generation.
- FSM, counter, shift register and output buffer live in conv_encoder.

## Test plan
- Frame 1,0,1,1 with K=3, FRAME_LEN=4 and out_ready=1: out_sym sequence 11,01,00,10,10,11 on six consecutive cycles, then done one cycle after the last symbol.
- Same frame with out_ready toggling 1,0,1,0: the same six symbols appear in order with no duplicates or drops, and out_sym stays stable while out_valid && !out_ready.
- start pulsed during ENCODE: error pulses once, the frame continues unaffected, and the symbol count stays FRAME_LEN+2.
- rst asserted after the second symbol: next cycle out_valid=0, busy=0, state IDLE. A following frame of all-zero bits yields all 00 symbols.
- Back-to-back frames (start asserted in the done cycle): the second frame's first bit 1 yields 11, confirming sr was cleared.
- in_valid held high in IDLE and DRAIN: in_ready=0 and no symbol is produced.
